// File: rtl/bus_debug_decoder.sv
// Address decoder and in-order response router between one CPU master and two
// slaves (debug region / default memory), with outstanding-response tracking.
//
// state  | meaning
// IDLE   | accepting reads and first write beats; pending responses may be outstanding
// WBURST | mid write burst; remaining beats go to locked_dbg regardless of address
module bus_debug_decoder #(
  parameter logic [27:0] DEBUG_BASE  = 28'he000_fff,
  parameter int          MAX_PENDING = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic [31:0] bus_address,
  input  logic [31:0] bus_writedata,
  input  logic [4:0]  bus_burstcount,
  input  logic [3:0]  bus_byteenable,
  input  logic        bus_read,
  input  logic        bus_write,

  output logic        s_waitrequest,
  output logic [31:0] s_readdata,
  output logic        s_readdatavalid,
  output logic        s_writeresponsevalid,
  output logic [1:0]  s_response,

  output logic [31:0] dbg_bus_address,
  output logic [31:0] dbg_bus_writedata,
  output logic [4:0]  dbg_bus_burstcount,
  output logic [3:0]  dbg_bus_byteenable,
  output logic        dbg_bus_read,
  output logic        dbg_bus_write,

  output logic [31:0] mem_bus_address,
  output logic [31:0] mem_bus_writedata,
  output logic [4:0]  mem_bus_burstcount,
  output logic [3:0]  mem_bus_byteenable,
  output logic        mem_bus_read,
  output logic        mem_bus_write,

  input  logic        dbg_s_waitrequest,
  input  logic [31:0] dbg_s_readdata,
  input  logic        dbg_s_readdatavalid,
  input  logic        dbg_s_writeresponsevalid,
  input  logic [1:0]  dbg_s_response,

  input  logic        mem_s_waitrequest,
  input  logic [31:0] mem_s_readdata,
  input  logic        mem_s_readdatavalid,
  input  logic        mem_s_writeresponsevalid,
  input  logic [1:0]  mem_s_response,

  output logic        protocol_err
);

  typedef enum logic {IDLE, WBURST} state_t;

  localparam logic [8:0] MAX_P = 9'(MAX_PENDING);

  state_t      state_q, state_d;
  logic [7:0]  pending_q, pending_d;
  logic [4:0]  beats_left_q, beats_left_d;
  logic        locked_dbg_q, locked_dbg_d;
  logic        protocol_err_q, protocol_err_d;

  logic        cmd_valid, cmd_dbg, tgt_dbg, eff_dbg;
  logic [4:0]  burst_n;
  logic [7:0]  add_req, add_acc, total;
  logic        stall, slave_wait, accept;
  logic        resp_ok, dbg_any, mem_any, eff_any, other_any, retire;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q        <= IDLE;
      pending_q      <= 8'd0;
      beats_left_q   <= 5'd0;
      locked_dbg_q   <= 1'b0;
      protocol_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      pending_q      <= pending_d;
      beats_left_q   <= beats_left_d;
      locked_dbg_q   <= locked_dbg_d;
      protocol_err_q <= protocol_err_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    beats_left_d   = beats_left_q;
    locked_dbg_d   = locked_dbg_q;

    cmd_valid = bus_read | bus_write;
    cmd_dbg   = (bus_address[31:4] == DEBUG_BASE);
    tgt_dbg   = (state_q == WBURST) ? locked_dbg_q : cmd_dbg;
    burst_n   = (bus_burstcount == 5'd0) ? 5'd1 : bus_burstcount;

    if (bus_read)
      add_req = {3'b000, burst_n};
    else if (bus_write && state_q == IDLE)
      add_req = 8'd1;
    else
      add_req = 8'd0;

    if (state_q == WBURST)
      stall = bus_read;
    else
      stall = ((pending_q != 8'd0) && (tgt_dbg != locked_dbg_q)) ||
              (({1'b0, pending_q} + {1'b0, add_req}) > MAX_P);

    slave_wait    = tgt_dbg ? dbg_s_waitrequest : mem_s_waitrequest;
    s_waitrequest = (cmd_valid & stall) | slave_wait;
    accept        = cmd_valid & ~s_waitrequest;
    add_acc       = accept ? add_req : 8'd0;
    total         = pending_q + add_acc;

    // With nothing outstanding the response can only belong to this cycle's command.
    eff_dbg   = (state_q == IDLE && pending_q == 8'd0) ? cmd_dbg : locked_dbg_q;
    resp_ok   = (total != 8'd0);
    dbg_any   = dbg_s_readdatavalid | dbg_s_writeresponsevalid;
    mem_any   = mem_s_readdatavalid | mem_s_writeresponsevalid;
    eff_any   = eff_dbg ? dbg_any : mem_any;
    other_any = eff_dbg ? mem_any : dbg_any;
    retire    = resp_ok & eff_any;

    s_readdata           = eff_dbg ? dbg_s_readdata : mem_s_readdata;
    s_response           = eff_dbg ? dbg_s_response : mem_s_response;
    s_readdatavalid      = resp_ok & (eff_dbg ? dbg_s_readdatavalid : mem_s_readdatavalid);
    s_writeresponsevalid = resp_ok & (eff_dbg ? dbg_s_writeresponsevalid
                                              : mem_s_writeresponsevalid);

    protocol_err_d = protocol_err_q | other_any | (eff_any & ~resp_ok);
    pending_d      = total - {7'd0, retire};

    dbg_bus_read  = bus_read  & ~stall &  tgt_dbg;
    dbg_bus_write = bus_write & ~stall &  tgt_dbg;
    mem_bus_read  = bus_read  & ~stall & ~tgt_dbg;
    mem_bus_write = bus_write & ~stall & ~tgt_dbg;

    case (state_q)
      IDLE: begin
        if (accept) begin
          locked_dbg_d = cmd_dbg;
          if (bus_write && burst_n > 5'd1) begin
            state_d      = WBURST;
            beats_left_d = burst_n - 5'd1;
          end
        end
      end
      WBURST: begin
        if (accept && bus_write) begin
          beats_left_d = beats_left_q - 5'd1;
          if (beats_left_q == 5'd1)
            state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign dbg_bus_address    = bus_address;
  assign dbg_bus_writedata  = bus_writedata;
  assign dbg_bus_burstcount = bus_burstcount;
  assign dbg_bus_byteenable = bus_byteenable;
  assign mem_bus_address    = bus_address;
  assign mem_bus_writedata  = bus_writedata;
  assign mem_bus_burstcount = bus_burstcount;
  assign mem_bus_byteenable = bus_byteenable;

  assign protocol_err = protocol_err_q;

endmodule

// File: tb/tb_bus_debug_decoder.sv
// Directed bench for bus_debug_decoder: single-cycle decode vectors from reset,
// then hand-written multi-cycle sequences for stalls, bursts, capacity and reset.
module tb_bus_debug_decoder;

  localparam logic [31:0] D = 32'hD0D0_0001;
  localparam logic [31:0] M = 32'h3E3E_0002;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [31:0] bus_address, bus_writedata;
  logic [4:0]  bus_burstcount;
  logic [3:0]  bus_byteenable;
  logic        bus_read, bus_write;
  logic        s_waitrequest;
  logic [31:0] s_readdata;
  logic        s_readdatavalid, s_writeresponsevalid;
  logic [1:0]  s_response;
  logic [31:0] dbg_bus_address, dbg_bus_writedata, mem_bus_address, mem_bus_writedata;
  logic [4:0]  dbg_bus_burstcount, mem_bus_burstcount;
  logic [3:0]  dbg_bus_byteenable, mem_bus_byteenable;
  logic        dbg_bus_read, dbg_bus_write, mem_bus_read, mem_bus_write;
  logic        dbg_s_waitrequest, dbg_s_readdatavalid, dbg_s_writeresponsevalid;
  logic [31:0] dbg_s_readdata, mem_s_readdata;
  logic [1:0]  dbg_s_response, mem_s_response;
  logic        mem_s_waitrequest, mem_s_readdatavalid, mem_s_writeresponsevalid;
  logic        protocol_err;

  int passed = 0;
  int total  = 0;

  bus_debug_decoder #(.MAX_PENDING(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .bus_address(bus_address), .bus_writedata(bus_writedata),
    .bus_burstcount(bus_burstcount), .bus_byteenable(bus_byteenable),
    .bus_read(bus_read), .bus_write(bus_write),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
    .s_readdatavalid(s_readdatavalid), .s_writeresponsevalid(s_writeresponsevalid),
    .s_response(s_response),
    .dbg_bus_address(dbg_bus_address), .dbg_bus_writedata(dbg_bus_writedata),
    .dbg_bus_burstcount(dbg_bus_burstcount), .dbg_bus_byteenable(dbg_bus_byteenable),
    .dbg_bus_read(dbg_bus_read), .dbg_bus_write(dbg_bus_write),
    .mem_bus_address(mem_bus_address), .mem_bus_writedata(mem_bus_writedata),
    .mem_bus_burstcount(mem_bus_burstcount), .mem_bus_byteenable(mem_bus_byteenable),
    .mem_bus_read(mem_bus_read), .mem_bus_write(mem_bus_write),
    .dbg_s_waitrequest(dbg_s_waitrequest), .dbg_s_readdata(dbg_s_readdata),
    .dbg_s_readdatavalid(dbg_s_readdatavalid),
    .dbg_s_writeresponsevalid(dbg_s_writeresponsevalid), .dbg_s_response(dbg_s_response),
    .mem_s_waitrequest(mem_s_waitrequest), .mem_s_readdata(mem_s_readdata),
    .mem_s_readdatavalid(mem_s_readdatavalid),
    .mem_s_writeresponsevalid(mem_s_writeresponsevalid), .mem_s_response(mem_s_response),
    .protocol_err(protocol_err)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr;
    logic        rd, wr;
    logic [4:0]  bc;
    logic        dw, mw, drv, mrv, dwr;
    logic [3:0]  exp_str;  // {dbg_rd, dbg_wr, mem_rd, mem_wr}
    logic        exp_wait, exp_rdv, exp_wrv;
    logic [31:0] exp_rdata;
    logic        exp_perr;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic idle_in();
    bus_address = 0; bus_writedata = 0; bus_burstcount = 0; bus_byteenable = 0;
    bus_read = 0; bus_write = 0;
    dbg_s_waitrequest = 0; dbg_s_readdatavalid = 0; dbg_s_writeresponsevalid = 0;
    dbg_s_response = 0;
    mem_s_waitrequest = 0; mem_s_readdatavalid = 0; mem_s_writeresponsevalid = 0;
    mem_s_response = 0;
  endtask

  task automatic cmd(input logic [31:0] a, input logic rd, input logic wr, input logic [4:0] bc);
    bus_address = a; bus_read = rd; bus_write = wr; bus_burstcount = bc;
    bus_writedata = a ^ 32'h5A5A_5A5A; bus_byteenable = 4'hF;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    idle_in();
    rst_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  function automatic logic [3:0] strobes();
    return {dbg_bus_read, dbg_bus_write, mem_bus_read, mem_bus_write};
  endfunction

  initial begin
    vecs[0]  = '{32'hE000_FFF0, 1'b1, 1'b0, 5'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1000, 1'b0, 1'b1, 1'b0, D, 1'b0};
    vecs[1]  = '{32'h0000_1000, 1'b1, 1'b0, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b0, M, 1'b0};
    vecs[2]  = '{32'hE000_FFFC, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b0, 1'b0, 1'b0, D, 1'b0};
    vecs[3]  = '{32'h0000_0000, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, M, 1'b0};
    vecs[4]  = '{32'h0000_1000, 1'b1, 1'b0, 5'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0, M, 1'b0};
    vecs[5]  = '{32'hE000_FFF4, 1'b1, 1'b0, 5'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1000, 1'b0, 1'b0, 1'b0, D, 1'b0};
    vecs[6]  = '{32'hE000_FFE0, 1'b1, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b0, M, 1'b0};
    vecs[7]  = '{32'hE001_FFF0, 1'b1, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b0, M, 1'b0};
    vecs[8]  = '{32'h0000_2000, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0010, 1'b0, 1'b1, 1'b0, M, 1'b0};
    vecs[9]  = '{32'h0000_3000, 1'b1, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, M, 1'b0};
    vecs[10] = '{32'h0000_3000, 1'b1, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b0, M, 1'b0};
    vecs[11] = '{32'hE000_FFF0, 1'b1, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1000, 1'b0, 1'b0, 1'b0, D, 1'b1};
    vecs[12] = '{32'h0000_0000, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, M, 1'b1};
    vecs[13] = '{32'h0000_0000, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, M, 1'b0};
    vecs[14] = '{32'hE000_FFF0, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0100, 1'b0, 1'b0, 1'b1, D, 1'b0};

    idle_in();
    dbg_s_readdata = 0;
    mem_s_readdata = 0;

    // Reset state: every output low with idle inputs
    do_reset();
    #2;
    chk("rst_ctl", {strobes(), s_waitrequest, s_readdatavalid, s_writeresponsevalid,
                    s_response, protocol_err}, 0);
    chk("rst_data", s_readdata | dbg_bus_address | mem_bus_address |
                    dbg_bus_writedata | mem_bus_writedata, 0);

    dbg_s_readdata = D;
    mem_s_readdata = M;

    foreach (vecs[i]) begin
      do_reset();
      @(negedge clk_i);
      cmd(vecs[i].addr, vecs[i].rd, vecs[i].wr, vecs[i].bc);
      dbg_s_waitrequest        = vecs[i].dw;
      mem_s_waitrequest        = vecs[i].mw;
      dbg_s_readdatavalid      = vecs[i].drv;
      mem_s_readdatavalid      = vecs[i].mrv;
      dbg_s_writeresponsevalid = vecs[i].dwr;
      #2;
      chk($sformatf("v%0d_strobes", i), strobes(), vecs[i].exp_str);
      chk($sformatf("v%0d_wait", i), s_waitrequest, vecs[i].exp_wait);
      chk($sformatf("v%0d_rdv", i), s_readdatavalid, vecs[i].exp_rdv);
      chk($sformatf("v%0d_wrv", i), s_writeresponsevalid, vecs[i].exp_wrv);
      chk($sformatf("v%0d_rdata", i), s_readdata, vecs[i].exp_rdata);
      chk($sformatf("v%0d_addr", i), {dbg_bus_address, mem_bus_address},
          {vecs[i].addr, vecs[i].addr});
      @(negedge clk_i);
      #2;
      chk($sformatf("v%0d_perr", i), protocol_err, vecs[i].exp_perr);
    end

    // Mem burst-4 read (latency 3) then a debug read that must wait for all beats
    do_reset();
    @(negedge clk_i);
    cmd(32'h0000_1000, 1'b1, 1'b0, 5'd4);
    #2;
    chk("seqA_mem_acc", {strobes(), s_waitrequest}, {4'b0010, 1'b0});
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk_i);
      cmd(32'hE000_FFF8, 1'b1, 1'b0, 5'd1);
      mem_s_readdatavalid = (c >= 3);
      #2;
      chk($sformatf("seqA_stall_c%0d", c), {strobes(), s_waitrequest}, {4'b0000, 1'b1});
      chk($sformatf("seqA_rdv_c%0d", c), s_readdatavalid, (c >= 3));
      if (c >= 3) chk($sformatf("seqA_rdata_c%0d", c), s_readdata, M);
    end
    @(negedge clk_i);
    mem_s_readdatavalid = 1'b0;
    dbg_s_readdatavalid = 1'b1;
    #2;
    chk("seqA_dbg_fwd", {strobes(), s_waitrequest, s_readdatavalid}, {4'b1000, 1'b0, 1'b1});
    chk("seqA_dbg_data", s_readdata, D);
    @(negedge clk_i);
    idle_in();
    #2;
    chk("seqA_perr", protocol_err, 1'b0);

    // 3-beat debug write burst; later beats carry address 0; read stalls mid-burst
    do_reset();
    @(negedge clk_i);
    cmd(32'hE000_FFF0, 1'b0, 1'b1, 5'd3);
    #2;
    chk("seqB_beat1", {strobes(), s_waitrequest}, {4'b0100, 1'b0});
    @(negedge clk_i);
    cmd(32'hE000_FFF0, 1'b1, 1'b0, 5'd1);
    #2;
    chk("seqB_rd_stall", {strobes(), s_waitrequest}, {4'b0000, 1'b1});
    for (int b = 2; b <= 3; b++) begin
      @(negedge clk_i);
      cmd(32'h0000_0000, 1'b0, 1'b1, 5'd3);
      #2;
      chk($sformatf("seqB_beat%0d", b), {strobes(), s_waitrequest}, {4'b0100, 1'b0});
    end
    @(negedge clk_i);
    idle_in();
    dbg_s_writeresponsevalid = 1'b1;
    #2;
    chk("seqB_wrresp", s_writeresponsevalid, 1'b1);
    @(negedge clk_i);
    idle_in();
    cmd(32'h0000_0000, 1'b1, 1'b0, 5'd1);
    mem_s_readdatavalid = 1'b1;
    #2;
    chk("seqB_mem_nostall", {strobes(), s_waitrequest, s_readdatavalid}, {4'b0010, 1'b0, 1'b1});
    chk("seqB_perr0", protocol_err, 1'b0);
    @(negedge clk_i);
    idle_in();
    dbg_s_writeresponsevalid = 1'b1;
    #2;
    chk("seqB_extra_wrresp", s_writeresponsevalid, 1'b0);
    @(negedge clk_i);
    idle_in();
    #2;
    chk("seqB_perr1", protocol_err, 1'b1);

    // Capacity: MAX_PENDING = 8, silent mem slave
    do_reset();
    @(negedge clk_i);
    cmd(32'h0000_1000, 1'b1, 1'b0, 5'd8);
    #2;
    chk("seqC_b8_acc", {strobes(), s_waitrequest}, {4'b0010, 1'b0});
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk_i);
      cmd(32'h0000_1004, 1'b1, 1'b0, 5'd1);
      #2;
      chk($sformatf("seqC_full_c%0d", c), {strobes(), s_waitrequest}, {4'b0000, 1'b1});
    end
    @(negedge clk_i);
    mem_s_readdatavalid = 1'b1;
    #2;
    chk("seqC_beat_ret", s_readdatavalid, 1'b1);
    @(negedge clk_i);
    mem_s_readdatavalid = 1'b0;
    #2;
    chk("seqC_after_ret", {strobes(), s_waitrequest}, {4'b0010, 1'b0});

    // Stray mem response with nothing outstanding: dropped, sticky error until reset
    do_reset();
    @(negedge clk_i);
    mem_s_readdatavalid = 1'b1;
    #2;
    chk("seqD_dropped", s_readdatavalid, 1'b0);
    @(negedge clk_i);
    mem_s_readdatavalid = 1'b0;
    #2;
    chk("seqD_perr_set", protocol_err, 1'b1);
    repeat (3) @(negedge clk_i);
    #2;
    chk("seqD_perr_sticky", protocol_err, 1'b1);
    do_reset();
    #2;
    chk("seqD_perr_clr", protocol_err, 1'b0);

    // Reset during beat 2 of a 4-beat write burst
    do_reset();
    @(negedge clk_i);
    cmd(32'hE000_FFF0, 1'b0, 1'b1, 5'd4);
    #2;
    chk("seqE_beat1", strobes(), 4'b0100);
    @(negedge clk_i);
    cmd(32'h0000_0000, 1'b0, 1'b1, 5'd4);
    rst_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    cmd(32'h0000_0000, 1'b1, 1'b0, 5'd1);
    #2;
    chk("seqE_post_rst", {strobes(), s_waitrequest}, {4'b0010, 1'b0});
    @(negedge clk_i);
    idle_in();
    dbg_s_writeresponsevalid = 1'b1;
    #2;
    chk("seqE_late_resp", s_writeresponsevalid, 1'b0);
    @(negedge clk_i);
    idle_in();
    #2;
    chk("seqE_late_perr", protocol_err, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/bus_debug_decoder.md
# bus_debug_decoder

Single-master, two-slave address decoder and response router sitting directly upstream of the simulation debug slave. It splits the CPU-side Avalon-MM style bus between the debug region (address[31:4] == DEBUG_BASE) and a default memory slave. It also tracks outstanding responses so that readdatavalid, writeresponsevalid and readdata from the correct slave are returned to the master in order. The block stalls the master whenever a new command would target a different slave while responses are still pending.

## Interface
- DEBUG_BASE, 28'he000_fff: value matched against bus_address[31:4] to select the debug slave.
- MAX_PENDING, 32: maximum outstanding response count (read beats plus write-burst responses), range 1..127.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; one clock; reset is synchronous and active-low.
- bus_address / bus_writedata  in  32 / 32  master command address and write data.
- bus_burstcount  in  5  burst length, legal 1..16; 0 is treated as 1.
- bus_byteenable  in  4  byte enables.
- bus_read / bus_write  in  1 / 1  master command strobes, never both high.
- s_waitrequest  out  1  stall to master.
- s_readdata  out  32  muxed read data.
- s_readdatavalid / s_writeresponsevalid  out  1 / 1  routed response strobes.
- s_response  out  2  routed response code.
- dbg_bus_* / mem_bus_*  out  same widths as bus_*  per-slave command copies; read and write are gated, other fields pass through.
- dbg_s_* / mem_s_*  in  same widths as s_*  per-slave responses.
- protocol_err  out  1  sticky; set by a stray response.

## Operation
- Command target: cmd_dbg = (bus_address[31:4] == DEBUG_BASE). In state WBURST the target is locked_dbg instead.
- State IDLE (pending may be nonzero):
  - Same target: a command is forwarded when pending == 0 or cmd target == locked_dbg.
  - Different target: a command to the other slave while pending != 0 is stalled. Both slave strobes stay 0 and s_waitrequest = 1.
- State WBURST: entered when a write beat with burstcount N > 1 is accepted in IDLE.
  - beats_left is loaded with N-1.
  - Following write beats go to locked_dbg regardless of address; each accept decrements beats_left.
  - The block returns to IDLE on the beat that makes beats_left 0.
  - A bus_read in WBURST is stalled.
- Accept: accept = (bus_read | bus_write) & ~s_waitrequest. s_waitrequest = stall | selected slave's waitrequest.
- Pending count update each cycle: pending_next = pending + add - retire.
  - add = burstcount for an accepted read; add = 1 for the accepted first beat of a write.
  - retire = 1 if the locked slave (or, when pending == 0, the slave targeted this cycle) asserts readdatavalid or writeresponsevalid.
- Capacity stall: a command is also stalled if pending + add > MAX_PENDING.
- Lock update: locked_dbg is updated on every accepted first beat.
- Response routing: s_readdata, s_readdatavalid, s_writeresponsevalid and s_response come from the effective target. The effective target is the cycle's command target when pending == 0 and the state is IDLE, and locked_dbg otherwise.
- Stray responses: a response strobe from the non-effective slave is dropped and sets protocol_err. protocol_err clears only on reset.

## Timing
- Commands and responses are combinational pass-through with zero added latency. Same-cycle responses (the debug slave answers in the accept cycle) retire in that cycle.
- Simultaneous accept and retire in one cycle is legal; pending changes by add - 1.
- Reset (rst_i = 0 at a clock edge):
  - State is IDLE; pending, beats_left, locked_dbg and protocol_err are 0.
  - With idle inputs, every output is 0.
  - A reset mid-burst or with responses pending discards all tracking. Late responses after reset count as stray.
- pending never underflows. A retire with pending == 0 and no accept this cycle is stray.

## Test plan
- Read to 0xE000_FFF0 with burstcount 1, where the debug slave answers in the same cycle: dbg_bus_read = 1, mem_bus_read = 0, s_readdatavalid = 1 in the same cycle, pending stays 0.
- Memory read to 0x0000_1000 with burstcount 4 and latency 3, immediately followed by a read to 0xE000_FFF8: the debug read waits (s_waitrequest = 1) until the 4th mem beat retires, then is forwarded on the next cycle.
- Write burst of 3 beats starting at 0xE000_FFF0, with beats 2 and 3 carrying address 0x0: all 3 beats appear on dbg_bus_write, mem_bus_write stays 0, and exactly one writeresponse is counted.
- MAX_PENDING = 8 with a mem slave that never responds: a read with burstcount 8 is accepted, and the next read with burstcount 1 stalls until 1 beat returns.
- mem_s_readdatavalid pulses while pending == 0: it is not forwarded and protocol_err goes to 1 and stays 1; a reset clears it to 0.
- Reset asserted in beat 2 of a 4-beat write burst: the next cycle is IDLE, pending = 0, and a new read to 0x0000_0000 is forwarded to mem without stall.
